z80_io_bridge: RTL and testbench

//  Parametrised CPU I/O front end for the VDP core. Synchronises and glitch-filters
//  raw Z80 read/write strobes, queues writes in a FIFO, and issues read/write requests
//  to the VDP with a held REQ/ACK handshake. Sits between top-level pins (cd, mode) and VDP REQ/WRT/ADR/DBO/DBI.

---
 rtl/z80_io_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_z80_io_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_bridge.sv
// Z80 I/O front end: synchronises and glitch-filters CPU strobes, queues writes, and issues held REQ/ACK requests to the VDP.
// Latency: raw strobe edge to req is 2+FILTER_LEN+2 cycles on an idle bridge; requests wait for ack, and writes beyond FIFO_DEPTH are dropped.
module z80_io_bridge #(
  parameter int ADDR_W     = 2,
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [ADDR_W-1:0]             port_adr,
  input  logic [7:0]                    cd_in,
  output logic [7:0]                    cd_out,
  output logic                          cd_oe,
  output logic                          req,
  output logic                          wrt,
  output logic [15:0]                   adr,
  output logic [7:0]                    dbo,
  input  logic                          ack,
  input  logic [7:0]                    dbi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          bus_err,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  // Strobe vectors: bit 0 = write strobe, bit 1 = read strobe.
  logic [1:0]        r_sync1, r_sync2, r_filt, r_filt_d;
  logic [CNT_W-1:0]  r_cnt [2];
  logic [ADDR_W-1:0] r_adr_s1, r_adr_s2;
  logic [7:0]        r_dat_s1, r_dat_s2;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [LVL_W-1:0]  r_level;

  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_adr;
  logic              r_overflow, r_bus_err;

  state_t            r_state, w_state_nxt;
  logic              r_req, r_wrt;
  logic [ADDR_W-1:0] r_adr;
  logic [7:0]        r_dbo, r_cd_out;

  logic              w_ev_wr, w_ev_rd, w_push_req, w_push, w_pop, w_full;
  logic              w_issue_wr, w_issue_rd, w_rd_done;
  logic              w_rd_set, w_ovf_set, w_err_set;
  logic [ENT_W-1:0]  w_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_filt   <= '1;
      r_filt_d <= '1;
      r_adr_s1 <= '0;
      r_adr_s2 <= '0;
      r_dat_s1 <= '0;
      r_dat_s2 <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= {csr_n, csw_n};
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      r_adr_s1 <= port_adr;
      r_adr_s2 <= r_adr_s1;
      r_dat_s1 <= cd_in;
      r_dat_s2 <= r_dat_s1;
      // Accept a new level only after FILTER_LEN consecutive differing samples.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_filt[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_ev_wr    = r_filt_d[0] & ~r_filt[0];
  assign w_ev_rd    = r_filt_d[1] & ~r_filt[1];
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push_req = w_ev_wr & ~w_ev_rd;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_rd_set   = w_ev_rd & ~w_ev_wr & ~r_rd_pend;
  assign w_err_set  = (w_ev_wr & w_ev_rd) | (w_ev_rd & ~w_ev_wr & r_rd_pend);
  assign w_head     = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_adr_s2, r_dat_s2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_adr   <= '0;
      r_overflow <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_rd_set) begin
        r_rd_pend <= 1'b1;
        r_rd_adr  <= r_adr_s2;
      end else if (w_rd_done) begin
        r_rd_pend <= 1'b0;
      end
      if (err_clr)        r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      if (err_clr)        r_bus_err  <= 1'b0;
      else if (w_err_set) r_bus_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Queued writes always go before a pending read.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_wr  = 1'b0;
    w_issue_rd  = 1'b0;
    w_pop       = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_issue_wr  = 1'b1;
          w_state_nxt = S_WR;
        end else if (r_rd_pend) begin
          w_issue_rd  = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_WR: begin
        if (ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (ack) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req    <= 1'b0;
      r_wrt    <= 1'b0;
      r_adr    <= '0;
      r_dbo    <= '0;
      r_cd_out <= '0;
    end else begin
      if (w_issue_wr) begin
        r_req <= 1'b1;
        r_wrt <= 1'b1;
        r_adr <= w_head[ENT_W-1:8];
        r_dbo <= w_head[7:0];
      end else if (w_issue_rd) begin
        r_req <= 1'b1;
        r_wrt <= 1'b0;
        r_adr <= r_rd_adr;
      end else if (w_pop || w_rd_done) begin
        r_req <= 1'b0;
        r_wrt <= 1'b0;
      end
      if (w_rd_done) r_cd_out <= dbi;
    end
  end

  assign req        = r_req;
  assign wrt        = r_wrt;
  assign adr        = {{(16-ADDR_W){1'b0}}, r_adr};
  assign dbo        = r_dbo;
  assign cd_out     = r_cd_out;
  assign cd_oe      = ~csr_n;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_z80_io_bridge.sv
// Directed bench for z80_io_bridge: write latency, glitch rejection, ordering, overflow, collisions, reset abort.
module tb_z80_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_n, csw_n;
  logic [1:0]  port_adr;
  logic [7:0]  cd_in, cd_out, dbo, dbi;
  logic        cd_oe, req, wrt, ack, overflow, bus_err, err_clr;
  logic [15:0] adr;
  logic [2:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  z80_io_bridge #(.ADDR_W(2), .FILTER_LEN(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .csr_n(csr_n), .csw_n(csw_n), .port_adr(port_adr),
    .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .req(req), .wrt(wrt), .adr(adr),
    .dbo(dbo), .ack(ack), .dbi(dbi), .fifo_level(fifo_level), .overflow(overflow),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    port_adr = a;
    cd_in    = d;
    csw_n    = 1'b0;
    repeat (8) tick();
    csw_n    = 1'b1;
    repeat (8) tick();
  endtask

  task automatic do_read(input logic [1:0] a);
    port_adr = a;
    csr_n    = 1'b0;
    repeat (8) tick();
    csr_n    = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 200 && req !== 1'b1; i++) tick();
    check({tag, "_req"}, req, 1);
  endtask

  task automatic pulse_ack(input logic [7:0] d);
    dbi = d;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3_dat [3];
    t3_dat = '{8'h11, 8'h22, 8'h33};

    reset = 1'b1; csr_n = 1'b1; csw_n = 1'b1; port_adr = '0; cd_in = '0;
    ack = 1'b0; dbi = '0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_req", req, 0);
    check("rst_wrt", wrt, 0);
    check("rst_adr", adr, 0);
    check("rst_dbo", dbo, 0);
    check("rst_cd_out", cd_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", bus_err, 0);
    check("rst_cd_oe", cd_oe, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Single write: req appears exactly on the 7th edge after the strobe falls.
    port_adr = 2'd1; cd_in = 8'hA5; csw_n = 1'b0;
    repeat (6) tick();
    check("t1_req_early", req, 0);
    tick();
    check("t1_req", req, 1);
    check("t1_wrt", wrt, 1);
    check("t1_adr", adr, 16'h0001);
    check("t1_dbo", dbo, 8'hA5);
    check("t1_level", fifo_level, 1);
    repeat (13) tick();
    csw_n = 1'b1;
    check("t1_req_hold", req, 1);
    pulse_ack(8'h00);
    check("t1_req_drop", req, 0);
    check("t1_level_pop", fifo_level, 0);
    repeat (10) tick();

    // Two-cycle glitch is filtered out.
    csw_n = 1'b0;
    repeat (2) tick();
    csw_n = 1'b1;
    repeat (20) tick();
    check("t2_req", req, 0);
    check("t2_level", fifo_level, 0);

    // Three writes then a read, each ack delayed 10 cycles.
    fork
      begin
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_read(2'd3);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          wait_req($sformatf("t3_%0d", k));
          repeat (10) tick();
          check($sformatf("t3_wrt_%0d", k), wrt, (k < 3) ? 1 : 0);
          if (k < 3) check($sformatf("t3_dbo_%0d", k), dbo, t3_dat[k]);
          else       check("t3_rd_adr", adr, 16'h0003);
          pulse_ack(8'h5A);
          check($sformatf("t3_drop_%0d", k), req, 0);
        end
      end
    join
    check("t3_cd_out", cd_out, 8'h5A);
    repeat (10) tick();

    // Overflow with ack held low.
    for (int i = 0; i < 5; i++) do_write(2'(i), 8'h41 + 8'(i));
    check("t4_level", fifo_level, 4);
    check("t4_ovf", overflow, 1);
    check("t4_req", req, 1);
    check("t4_dbo_head", dbo, 8'h41);
    pulse_clr();
    check("t4_ovf_clr", overflow, 0);
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("t4_%0d", k));
      check($sformatf("t4_dbo_%0d", k), dbo, 8'h41 + 8'(k));
      pulse_ack(8'h00);
    end
    repeat (30) tick();
    check("t4_no_fifth", req, 0);
    check("t4_level_end", fifo_level, 0);

    // Collision and read-while-pending.
    csr_n = 1'b0; csw_n = 1'b0;
    repeat (10) tick();
    check("t5_cd_oe", cd_oe, 1);
    csr_n = 1'b1; csw_n = 1'b1;
    repeat (10) tick();
    check("t5_coll_req", req, 0);
    check("t5_coll_err", bus_err, 1);
    check("t5_coll_level", fifo_level, 0);
    pulse_clr();
    check("t5_err_clr", bus_err, 0);
    do_read(2'd2);
    check("t5_rd_req", req, 1);
    check("t5_rd_wrt", wrt, 0);
    check("t5_rd_adr", adr, 16'h0002);
    check("t5_err_before", bus_err, 0);
    do_read(2'd1);
    check("t5_err_pend", bus_err, 1);
    pulse_ack(8'h3C);
    check("t5_cd_out", cd_out, 8'h3C);
    check("t5_rd_drop", req, 0);
    repeat (20) tick();
    check("t5_no_second", req, 0);
    pulse_ack(8'hFF);
    check("t5_stray_ack", cd_out, 8'h3C);
    pulse_clr();

    // Reset while a write request is outstanding.
    do_write(2'd1, 8'h99);
    do_write(2'd2, 8'h98);
    check("t6_req_before", req, 1);
    check("t6_level_before", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    check("t6_req_async", req, 0);
    check("t6_level_async", fifo_level, 0);
    tick();
    reset = 1'b0;
    tick();
    do_write(2'd3, 8'h77);
    check("t6_req_after", req, 1);
    check("t6_wrt_after", wrt, 1);
    check("t6_adr_after", adr, 16'h0003);
    check("t6_dbo_after", dbo, 8'h77);
    pulse_ack(8'h00);
    check("t6_drop_after", req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
